avl_bus_rsp_router: RTL and testbench

AVL_BUS_RSP_ROUTER -- requirements
Module: avl_bus_rsp_router

---
 rtl/avl_bus_rsp_router.sv | 105 ++++++++++
 tb/tb_avl_bus_rsp_router.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_bus_rsp_router.sv
// Read-response router for a shared Avalon-style bus: records the owner of each accepted read beat
// in order and steers slave_readdatavalid back to it. Optional sticky error: AVL_BUS_RSP_ROUTER_ERR_EN.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 8
`endif

module avl_bus_rsp_router #(
  parameter int unsigned MASTER_NUM = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned SEL_W = $clog2(MASTER_NUM),
  localparam int unsigned BC_W  = $clog2(`ALV_BURST_MAX_COUNT),
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rest,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  cmd_read,
  input  logic                  cmd_write,
  input  logic                  cmd_begin_burst,
  input  logic [BC_W-1:0]       cmd_burst_count,
  input  logic                  slave_request_ready,
  output logic                  master_request_ready,
  input  logic                  slave_readdatavalid,
  output logic [MASTER_NUM-1:0] master_readdatavalid,
  output logic [SEL_W-1:0]      rsp_sel,
  output logic [CNT_W-1:0]      pending,
  output logic                  err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [SEL_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] pending_q;
  logic [CNT_W-1:0] free_slots;
  logic             room;
  logic             push;
  logic             pop;

  // Space is judged on registered occupancy only; a same-cycle pop never frees room for a push.
  assign free_slots = CNT_W'(FIFO_DEPTH) - pending_q;

  always_comb begin
    room = 1'b1;
    if (cmd_read) begin
      if (cmd_begin_burst) begin
        // Reserve the whole burst up front so later beats never stall on space.
        room = free_slots >= (CNT_W'(cmd_burst_count) + CNT_W'(1));
      end else begin
        room = pending_q < CNT_W'(FIFO_DEPTH);
      end
    end
  end

  assign master_request_ready = slave_request_ready && (cmd_read || cmd_write) && room;
  assign push                 = cmd_read && master_request_ready;
  assign pop                  = slave_readdatavalid && (pending_q != '0);
  assign rsp_sel              = (pending_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign master_readdatavalid = pop ? (MASTER_NUM'(1) << rsp_sel) : '0;
  assign pending              = pending_q;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pending_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        pending_q <= pending_q + CNT_W'(1);
      end else if (pop && !push) begin
        pending_q <= pending_q - CNT_W'(1);
      end
    end
  end

  // Entries are qualified by pending, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sel;
    end
  end

`ifdef AVL_BUS_RSP_ROUTER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      err_q <= 1'b0;
    end else if (slave_readdatavalid && (pending_q == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_avl_bus_rsp_router.sv
// Directed bench for avl_bus_rsp_router with a queue-based owner model checked every cycle.
`ifndef ALV_BURST_MAX_COUNT
`define ALV_BURST_MAX_COUNT 8
`endif

module tb_avl_bus_rsp_router;

  localparam int MASTER_NUM = 8;
  localparam int DEPTH      = 8;
  localparam int SEL_W      = $clog2(MASTER_NUM);
  localparam int BC_W       = $clog2(`ALV_BURST_MAX_COUNT);
  localparam int CNT_W      = $clog2(DEPTH) + 1;

`ifdef AVL_BUS_RSP_ROUTER_ERR_EN
  localparam int ErrOn = 1;
`else
  localparam int ErrOn = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rest;
  logic [SEL_W-1:0]      sel;
  logic                  cmd_read, cmd_write, cmd_begin_burst;
  logic [BC_W-1:0]       cmd_burst_count;
  logic                  slave_request_ready;
  logic                  master_request_ready;
  logic                  slave_readdatavalid;
  logic [MASTER_NUM-1:0] master_readdatavalid;
  logic [SEL_W-1:0]      rsp_sel;
  logic [CNT_W-1:0]      pending;
  logic                  err;

  int checks   = 0;
  int failures = 0;

  avl_bus_rsp_router #(
    .MASTER_NUM(MASTER_NUM),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                 (clk),
    .rest                (rest),
    .sel                 (sel),
    .cmd_read            (cmd_read),
    .cmd_write           (cmd_write),
    .cmd_begin_burst     (cmd_begin_burst),
    .cmd_burst_count     (cmd_burst_count),
    .slave_request_ready (slave_request_ready),
    .master_request_ready(master_request_ready),
    .slave_readdatavalid (slave_readdatavalid),
    .master_readdatavalid(master_readdatavalid),
    .rsp_sel             (rsp_sel),
    .pending             (pending),
    .err                 (err)
  );

  always #5 clk = ~clk;

  // Model: ordered queue of read-beat owners plus a sticky error flag.
  logic [SEL_W-1:0] q[$];
  int               err_m = 0;

  function automatic int exp_ready();
    int free_n;
    free_n = DEPTH - q.size();
    if (!slave_request_ready) return 0;
    if (cmd_read) begin
      if (cmd_begin_burst) return (free_n >= int'(cmd_burst_count) + 1) ? 1 : 0;
      return (q.size() < DEPTH) ? 1 : 0;
    end
    return 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      q.delete();
      err_m = 0;
    end else begin
      int  did_pop;
      int  did_push;
      did_pop  = (slave_readdatavalid && q.size() != 0) ? 1 : 0;
      did_push = (cmd_read && exp_ready() == 1) ? 1 : 0;
      if (slave_readdatavalid && q.size() == 0 && ErrOn == 1) err_m = 1;
      if (did_pop == 1) void'(q.pop_front());
      if (did_push == 1) q.push_back(sel);
    end
  end

  always @(negedge clk) begin
    int exp_rdv;
    int exp_sel;
    exp_rdv = 0;
    exp_sel = 0;
    if (q.size() != 0) exp_sel = int'(q[0]);
    if (slave_readdatavalid && q.size() != 0) exp_rdv = 1 << exp_sel;
    chk("pending", int'(pending), q.size());
    chk("rsp_sel", int'(rsp_sel), exp_sel);
    chk("mrdv", int'(master_readdatavalid), exp_rdv);
    chk("err", int'(err), err_m);
    if (cmd_read || cmd_write) chk("ready", int'(master_request_ready), exp_ready());
  end

  task automatic set(input logic rd, input logic wr, input logic bb, input int bc, input int s,
                     input logic srr, input logic rdv);
    cmd_read            = rd;
    cmd_write           = wr;
    cmd_begin_burst     = bb;
    cmd_burst_count     = BC_W'(bc);
    sel                 = SEL_W'(s);
    slave_request_ready = srr;
    slave_readdatavalid = rdv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int s2_sel[3]   = '{1, 5, 2};
  int s2_onehot[3] = '{8'h02, 8'h20, 8'h04};

  initial begin
    rest = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", int'(pending), 0);
    chk("rst_mrdv", int'(master_readdatavalid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rsp_sel", int'(rsp_sel), 0);
    tick();
    rest = 1'b1;

    // Single read from master 3, response two cycles later.
    set(1, 0, 0, 0, 3, 1, 0); @(negedge clk); chk("s1_ready", int'(master_request_ready), 1);
    tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("s1_pend1", int'(pending), 1); chk("s1_rsp_sel", int'(rsp_sel), 3);
    tick();
    set(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("s1_onehot", int'(master_readdatavalid), 8'b0000_1000);
    tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("s1_pend0", int'(pending), 0);
    tick();

    // Back-to-back reads 1,5,2 return in order.
    for (int i = 0; i < 3; i++) begin
      set(1, 0, 0, 0, s2_sel[i], 1, 0); tick();
    end
    for (int i = 0; i < 3; i++) begin
      set(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
      chk("s2_rsp_sel", int'(rsp_sel), s2_sel[i]);
      chk("s2_onehot", int'(master_readdatavalid), s2_onehot[i]);
      tick();
    end

    // Writes follow slave ready and never push.
    set(0, 1, 0, 0, 4, 0, 0); @(negedge clk); chk("wr_ready0", int'(master_request_ready), 0);
    tick();
    set(0, 1, 0, 0, 4, 1, 0); @(negedge clk); chk("wr_ready1", int'(master_request_ready), 1);
    tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("wr_nopush", int'(pending), 0);
    tick();

    // Fill to full; a same-cycle pop does not free space for the push.
    for (int i = 0; i < DEPTH; i++) begin
      set(1, 0, 0, 0, i, 1, 0); tick();
    end
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("s3_full", int'(pending), 8);
    tick();
    set(1, 0, 0, 0, 6, 1, 1); @(negedge clk);
    chk("s3_ready0", int'(master_request_ready), 0);
    chk("s3_pop_head", int'(master_readdatavalid), 8'h01);
    tick();
    set(1, 0, 0, 0, 6, 1, 0); @(negedge clk);
    chk("s3_pend7", int'(pending), 7); chk("s3_ready1", int'(master_request_ready), 1);
    tick();
    repeat (3) begin
      set(0, 0, 0, 0, 0, 0, 1); tick();
    end

    // Burst admission reserves the whole burst.
    set(1, 0, 1, 3, 7, 1, 0); @(negedge clk);
    chk("s4_pend5", int'(pending), 5); chk("s4_ready0", int'(master_request_ready), 0);
    tick();
    repeat (2) begin
      set(0, 0, 0, 0, 0, 0, 1); tick();
    end
    set(1, 0, 1, 3, 7, 1, 0); @(negedge clk);
    chk("s4_pend3", int'(pending), 3); chk("s4_ready1", int'(master_request_ready), 1);
    tick();
    repeat (3) begin
      set(1, 0, 0, 0, 7, 1, 0); tick();
    end
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("s4_pend7", int'(pending), 7);
    tick();
    set(1, 0, 0, 0, 2, 1, 1); tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("pushpop_pend", int'(pending), 7);
    tick();
    repeat (7) begin
      set(0, 0, 0, 0, 0, 0, 1); tick();
    end
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("drain_pend0", int'(pending), 0);
    tick();

    // Stray valid with nothing outstanding.
    set(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("s5_mrdv", int'(master_readdatavalid), 0); chk("s5_pend", int'(pending), 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk);
    chk("s5_pend_after", int'(pending), 0); chk("s5_err", int'(err), ErrOn);
    tick();

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) begin
      set(1, 0, 0, 0, i + 1, 1, 0); tick();
    end
    set(0, 0, 0, 0, 0, 0, 1);
    #2 rest = 1'b0;
    #1;
    chk("s6_pend", int'(pending), 0);
    chk("s6_mrdv", int'(master_readdatavalid), 0);
    chk("s6_rsp_sel", int'(rsp_sel), 0);
    chk("s6_err", int'(err), 0);
    set(0, 0, 0, 0, 0, 0, 0);
    tick();
    rest = 1'b1;
    set(1, 0, 0, 0, 0, 1, 0); @(negedge clk); chk("s6_ready", int'(master_request_ready), 1);
    tick();
    set(0, 0, 0, 0, 0, 0, 1); @(negedge clk);
    chk("s6_onehot", int'(master_readdatavalid), 8'h01);
    tick();
    set(0, 0, 0, 0, 0, 0, 0); @(negedge clk); chk("s6_pend0", int'(pending), 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
